mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences and shares the single memory port of the multi-cycle processor between three requesters: instruction fetch (IF, from the control unit's FETCH state), data access (DM, for lw/sw/push/pop in the MEM state), and a debug/program loader (DBG). It serializes accesses, drives the memory read/write strobes for a fixed-latency synchronous memory, and returns read data with a one-cycle acknowledge. It sits between CONTROL_UNIT/datapath and the memory model.

## Interface
- ADDR_WIDTH, 26, memory word address width
- DATA_WIDTH, 32, data word width
- MEM_LATENCY, 2, read latency in rising edges (legal 1..7)

- CLK  in  1  clock, rising-edge active
- RST  in  1  reset, asynchronous, active-low
- IF_REQ  in  1  fetch request (read only)
- IF_ADDR  in  ADDR_WIDTH  fetch address
- IF_ACK  out  1  one-cycle completion pulse
- IF_RDATA  out  DATA_WIDTH  fetched word, valid while IF_ACK=1, held after
- DM_REQ / DBG_REQ  in  1  data / debug request
- DM_WE / DBG_WE  in  1  1=write, 0=read
- DM_ADDR / DBG_ADDR  in  ADDR_WIDTH  address
- DM_WDATA / DBG_WDATA  in  DATA_WIDTH  write data
- DM_ACK / DBG_ACK  out  1  completion pulse
- DM_RDATA / DBG_RDATA  out  DATA_WIDTH  read data, valid while ACK=1, held after
- MEM_READ  out  1  memory read strobe
- MEM_WRITE  out  1  memory write strobe
- MEM_ADDR  out  ADDR_WIDTH  memory address
- MEM_WDATA  out  DATA_WIDTH  memory write data
- MEM_RDATA  in  DATA_WIDTH  memory read data
- GRANT_ID  out  2  0=none, 1=IF, 2=DM, 3=DBG
- BUSY  out  1  1 when state is not IDLE

## Operation
- States: IDLE, ACCESS, DONE. All outputs registered.
- IDLE: at a rising edge with any REQ=1, pick winner; latch its ADDR/WE/WDATA onto MEM_ADDR/MEM_WDATA; set GRANT_ID; assert MEM_READ (read) or MEM_WRITE (write); load latency counter with MEM_LATENCY; go ACCESS.
- Priority: DBG absolute highest. IF vs DM round-robin: pointer holds last served of {IF, DM}; on simultaneous IF_REQ/DM_REQ, the one not last served wins. Pointer resets to "IF last served" (DM wins first tie). DBG grants do not move the pointer.
- ACCESS, write: MEM_WRITE high exactly one cycle; at next edge pulse winner ACK, go DONE.
- ACCESS, read: MEM_READ high exactly one cycle; counter decrements each edge; at the MEM_LATENCY-th edge after MEM_READ rose, capture MEM_RDATA into winner RDATA, pulse winner ACK, go DONE.
- DONE: ACK high this cycle only; MEM_READ/MEM_WRITE=0; GRANT_ID held; at next edge go IDLE, GRANT_ID=0. REQ values are ignored in DONE.
- Requester protocol: hold REQ and fields stable until ACK; drop REQ in the ACK cycle. A REQ still high in IDLE is a new request.
- Fields changed after grant are ignored (latched at grant). REQ dropped before ACK: access still completes, ACK still pulsed.
- RDATA of non-winning requesters unchanged. Write ACKs do not change RDATA.
- MEM_ADDR/MEM_WDATA hold last value outside ACCESS.

## Timing
- Reset (RST=0, async): state IDLE, all ACK=0, all RDATA=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WDATA=0, GRANT_ID=0, BUSY=0, counter=0, RR pointer=IF. Reset mid-access aborts with no ACK; requesters must re-request.
- Edge e0 grant. Write: MEM_WRITE high e0-e1, ACK high e1-e2, IDLE at e2, next grant earliest e3.
- Read: MEM_READ high e0-e1, capture at e(MEM_LATENCY), ACK high e(L)-e(L+1), IDLE at e(L+1), next grant earliest e(L+2).
- Throughput: one write per 3 cycles, one read per MEM_LATENCY+2 cycles.
- Never MEM_READ and MEM_WRITE both high; never more than one ACK high.

## Test plan
- Reset with IF_REQ=1 held low RST: all outputs 0; release RST, IF_ADDR=0x0000010, memory returns 0x20010005, L=2 -> MEM_READ 1 cycle, IF_ACK 2 edges after grant, IF_RDATA=0x20010005, GRANT_ID=1 during access.
- DM write addr 0x03FFFFF data 0xDEADBEEF -> MEM_WRITE one cycle with those values, DM_ACK next cycle, DM_RDATA unchanged.
- IF_REQ and DM_REQ raised same edge, re-raised after each ACK, 4 rounds -> grant order DM, IF, DM, IF.
- DBG_REQ with IF_REQ and DM_REQ all high -> DBG served first, then DM (pointer unchanged), then IF.
- RST pulsed low during read ACCESS -> no ACK, outputs zero immediately (async); re-request completes normally.
- MEM_LATENCY=1 and 7 builds: read ACK exactly 1 and 7 edges after grant; DM_REQ dropped mid-access still yields DM_ACK.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency synchronous memory port between fetch, data and debug requesters.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IF_REQ,
  input  logic [ADDR_WIDTH-1:0] IF_ADDR,
  output logic                  IF_ACK,
  output logic [DATA_WIDTH-1:0] IF_RDATA,
  input  logic                  DM_REQ,
  input  logic                  DM_WE,
  input  logic [ADDR_WIDTH-1:0] DM_ADDR,
  input  logic [DATA_WIDTH-1:0] DM_WDATA,
  output logic                  DM_ACK,
  output logic [DATA_WIDTH-1:0] DM_RDATA,
  input  logic                  DBG_REQ,
  input  logic                  DBG_WE,
  input  logic [ADDR_WIDTH-1:0] DBG_ADDR,
  input  logic [DATA_WIDTH-1:0] DBG_WDATA,
  output logic                  DBG_ACK,
  output logic [DATA_WIDTH-1:0] DBG_RDATA,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic [1:0]            GRANT_ID,
  output logic                  BUSY
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] win;
  logic win_we, rr_dm, we_q, last;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [2:0] cnt;
  // rr_dm=1 means DM was the last of {IF, DM} served, so IF wins the next tie
  always_comb begin
    win = DBG_REQ ? 2'd3 : (IF_REQ && DM_REQ) ? (rr_dm ? 2'd1 : 2'd2) : IF_REQ ? 2'd1 : DM_REQ ? 2'd2 : 2'd0;
    win_we = (win == 2'd3) ? DBG_WE : (win == 2'd2) ? DM_WE : 1'b0;
    win_addr = (win == 2'd3) ? DBG_ADDR : (win == 2'd2) ? DM_ADDR : IF_ADDR;
    win_wdata = (win == 2'd3) ? DBG_WDATA : DM_WDATA;
    last = (state == ACCESS) && (we_q || cnt == 3'd1);
    state_nx = state;
    if (state == IDLE && win != 2'd0) state_nx = ACCESS;
    else if (last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      IF_ACK <= 1'b0;
      DM_ACK <= 1'b0;
      DBG_ACK <= 1'b0;
      IF_RDATA <= '0;
      DM_RDATA <= '0;
      DBG_RDATA <= '0;
      MEM_READ <= 1'b0;
      MEM_WRITE <= 1'b0;
      MEM_ADDR <= '0;
      MEM_WDATA <= '0;
      GRANT_ID <= 2'd0;
      cnt <= 3'd0;
      rr_dm <= 1'b0;
      we_q <= 1'b0;
    end else begin
      IF_ACK <= 1'b0;
      DM_ACK <= 1'b0;
      DBG_ACK <= 1'b0;
      if (state == IDLE && win != 2'd0) begin
        GRANT_ID <= win;
        MEM_ADDR <= win_addr;
        if (win != 2'd1) MEM_WDATA <= win_wdata;
        MEM_READ <= !win_we;
        MEM_WRITE <= win_we;
        we_q <= win_we;
        cnt <= 3'(MEM_LATENCY);
        if (win == 2'd1) rr_dm <= 1'b0;
        if (win == 2'd2) rr_dm <= 1'b1;
      end
      if (state == ACCESS) begin
        MEM_READ <= 1'b0;
        MEM_WRITE <= 1'b0;
        if (cnt != 3'd0) cnt <= cnt - 3'd1;
      end
      if (last) begin
        IF_ACK <= GRANT_ID == 2'd1;
        DM_ACK <= GRANT_ID == 2'd2;
        DBG_ACK <= GRANT_ID == 2'd3;
        if (!we_q && GRANT_ID == 2'd1) IF_RDATA <= MEM_RDATA;
        if (!we_q && GRANT_ID == 2'd2) DM_RDATA <= MEM_RDATA;
        if (!we_q && GRANT_ID == 2'd3) DBG_RDATA <= MEM_RDATA;
      end
      if (state == DONE) GRANT_ID <= 2'd0;
    end
  end
  assign BUSY = state != IDLE;
endmodule
